// File: rtl/gfx_pkg.sv
// gfx_pkg: shared display-path types, default 640x480@60 timing and
// colour-bar constants. The bar-index field of tap_t exists only when
// VGA_TEST_PATTERN_EN is defined.
package gfx_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    // Counter width for px/py; both totals must fit.
    localparam int CNT_W = 10;

    // 640x480@60 defaults (pixel ticks / lines).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Colour bars, left to right.
    localparam color_t BAR_WHITE   = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam color_t BAR_YELLOW  = '{r: 4'hF, g: 4'hF, b: 4'h0};
    localparam color_t BAR_CYAN    = '{r: 4'h0, g: 4'hF, b: 4'hF};
    localparam color_t BAR_GREEN   = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam color_t BAR_MAGENTA = '{r: 4'hF, g: 4'h0, b: 4'hF};
    localparam color_t BAR_RED     = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam color_t BAR_BLUE    = '{r: 4'h0, g: 4'h0, b: 4'hF};
    localparam color_t BAR_BLACK   = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // One delay-line slot. All-zero is the blank/inactive state.
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] bar;
`endif
    } tap_t;

    function automatic color_t bar_color(input logic [2:0] idx);
        color_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage enable-gated shift register, synchronous
// reset to zero. DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock/reset/enable have no role without storage.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, en};
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] pipe;

            // Shift one slot per enabled tick; reset flushes to blank.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe <= '0;
                end else if (en) begin
                    pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel-timing master. Free-running h/v counters
// feed the rasterizer; returned colour is blank-gated and registered
// together with sync so all vga_* pins line up. The blank/sync flags
// are delayed PIPE_DLY ticks to match rasterizer latency.
// Optional: VGA_TEST_PATTERN_EN adds test_mode and 8 vertical colour bars.
module vga_timing_gen
    import gfx_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] py,
    output logic             frame,
    output logic             active,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    input  logic [3:0]       r_in,
    input  logic [3:0]       g_in,
    input  logic [3:0]       b_in,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    // Last visible line; wrapping off it starts vertical blanking.
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_raw;
    logic             vs_raw;
    tap_t             tap_d;
    tap_t             tap_q;
    color_t           rgb_sel;

    // Raster counters: h wraps each line, v wraps each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign px     = h_cnt;
    assign py     = v_cnt;
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // One-clk pulse after the tick that enters vertical blanking; the
    // unconditional clear keeps it one clk wide at any pix_en rate.
    always_ff @(posedge clk) begin
        if (rst) frame <= 1'b0;
        else     frame <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;

    // Bar index from h_cnt by threshold compare (no divider).
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= CNT_W'(i * (H_ACTIVE / 8))) bar_idx = 3'(i);
        end
    end
`endif

    // Pack the per-pixel flags that must travel with the colour.
    always_comb begin
        tap_d        = '0;
        tap_d.active = active;
        tap_d.hs     = hs_raw;
        tap_d.vs     = vs_raw;
`ifdef VGA_TEST_PATTERN_EN
        tap_d.bar    = bar_idx;
`endif
    end

    vga_delay_line #(
        .WIDTH($bits(tap_t)),
        .DEPTH(PIPE_DLY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (tap_d),
        .q   (tap_q)
    );

    // Pick colour source, then force black outside the visible area.
    always_comb begin
        rgb_sel = '{r: r_in, g: g_in, b: b_in};
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) rgb_sel = bar_color(tap_q.bar);
`endif
        if (!tap_q.active) rgb_sel = '0;
    end

    // Output register: colour and sync launched together on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else if (pix_en) begin
            vga_r  <= rgb_sel.r;
            vga_g  <= rgb_sel.g;
            vga_b  <= rgb_sel.b;
            vga_hs <= ~(tap_q.hs ^ HS_POL);
            vga_vs <= ~(tap_q.vs ^ VS_POL);
        end
    end

endmodule
